// File: rtl/seg_scan_ctrl_if.sv
// Scan controller bundle: digit patterns and mask in,
// shared segment bus, digit enables and frame pulse out.
interface seg_scan_ctrl_if;
    logic       enable;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [7:0] seg3;
    logic [7:0] seg4;
    logic [7:0] seg5;
    logic [5:0] blank_mask;
    logic [7:0] seg_out;
    logic [5:0] dig_en;
    logic [2:0] scan_idx;
    logic       frame_done;

    modport master (
        output enable, seg0, seg1, seg2, seg3, seg4, seg5, blank_mask,
        input  seg_out, dig_en, scan_idx, frame_done
    );

    modport slave (
        input  enable, seg0, seg1, seg2, seg3, seg4, seg5, blank_mask,
        output seg_out, dig_en, scan_idx, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan controller with per-frame snapshot,
// inter-digit blanking and per-digit suppression mask.
module seg_scan_ctrl #(
    parameter int DIGITS = 6,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 50
) (
    input logic            clk,
    input logic            reset,
    seg_scan_ctrl_if.slave bus
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
    localparam logic [2:0]    LAST    = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [5:0][7:0] snap;
    logic [5:0]      mask;
    logic [5:0][7:0] seg_in;
    logic [7:0]      seg_q;
    logic [5:0]      dig_q;
    logic [2:0]      idx_q;
    logic            fd_q;

    // Gather the six live patterns for a single-edge snapshot
    assign seg_in = {bus.seg5, bus.seg4, bus.seg3,
                     bus.seg2, bus.seg1, bus.seg0};

    assign bus.seg_out    = seg_q;
    assign bus.dig_en     = dig_q;
    assign bus.scan_idx   = idx_q;
    assign bus.frame_done = fd_q;

    // Scan FSM: outputs are set on the edge entering each state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            snap  <= '0;
            mask  <= '0;
            seg_q <= '0;
            dig_q <= '0;
            idx_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        snap  <= seg_in;
                        mask  <= bus.blank_mask;
                        idx_q <= '0;
                        cnt   <= '0;
                        state <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (!bus.enable) begin
                        idx_q <= '0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt == BL_LAST) begin
                        cnt   <= '0;
                        state <= ST_SHOW;
                        if (!mask[idx_q]) begin
                            dig_q <= 6'b1 << idx_q;
                            seg_q <= snap[idx_q];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DW_LAST && idx_q == LAST) begin
                        seg_q <= '0;
                        dig_q <= '0;
                        cnt   <= '0;
                        idx_q <= '0;
                        fd_q  <= 1'b1;
                        if (bus.enable) begin
                            snap  <= seg_in;
                            mask  <= bus.blank_mask;
                            state <= ST_BLANK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (!bus.enable) begin
                        seg_q <= '0;
                        dig_q <= '0;
                        cnt   <= '0;
                        idx_q <= '0;
                        state <= ST_IDLE;
                    end else if (cnt == DW_LAST) begin
                        seg_q <= '0;
                        dig_q <= '0;
                        cnt   <= '0;
                        idx_q <= idx_q + 3'd1;
                        state <= ST_BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
